// File: rtl/pool_stream_tx.sv
// 2x2 signed max-pool back end: two-stage reduction, FWFT FIFO and raster-order
// pixel stream with end-of-map flag and frame-done pulse.
module pool_stream_tx #(
    parameter int CH    = 32,
    parameter int DW    = 32,
    parameter int OUT_H = 17,
    parameter int OUT_W = 13,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    output logic          ready_out,
    input  logic [DW-1:0] win_in [0:CH-1][0:1][0:1],
    output logic [DW-1:0] data_out [0:CH-1],
    output logic          valid_out,
    input  logic          ready_in,
    output logic          last_out,
    output logic          frame_done
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int RW  = $clog2(OUT_H);
    localparam int CLW = $clog2(OUT_W);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and ready_out depends only on
    // registered state so no combinational path runs from ready_in to ready_out.
    logic accept;
    logic pop;

    logic [DW-1:0] ma0 [0:CH-1];
    logic [DW-1:0] ma1 [0:CH-1];
    logic [DW-1:0] mb  [0:CH-1];
    logic          va;
    logic          vb;

    logic [CH*DW-1:0] mem [0:DEPTH-1];
    logic [CH*DW-1:0] push_word;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW:0]      occupancy;

    logic [RW-1:0]  row;
    logic [CLW-1:0] col;
    logic           at_last;

    function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    // Pipeline stages and queued words both count against the FIFO space.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, va} + {{CW{1'b0}}, vb};
    assign ready_out = occupancy < (CW+1)'(DEPTH);
    assign accept    = valid_in && ready_out;
    assign valid_out = (count != '0);
    assign pop       = valid_out && ready_in;
    assign at_last   = (row == RW'(OUT_H - 1)) && (col == CLW'(OUT_W - 1));
    assign last_out  = valid_out && at_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            va <= 1'b0;
            vb <= 1'b0;
        end else begin
            va <= accept;
            vb <= va;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (accept) begin
                ma0[c] <= smax(win_in[c][0][0], win_in[c][0][1]);
                ma1[c] <= smax(win_in[c][1][0], win_in[c][1][1]);
            end
            if (va) begin
                mb[c] <= smax(ma0[c], ma1[c]);
            end
        end
    end

    always_comb begin
        push_word = '0;
        for (int c = 0; c < CH; c++) begin
            push_word[c*DW +: DW] = mb[c];
        end
    end

    always_ff @(posedge clk) begin
        if (vb) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (vb) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({vb, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head is gated so an empty FIFO shows zero rather than stale contents.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            data_out[c] = valid_out ? mem[rd_ptr][c*DW +: DW] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row        <= '0;
            col        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop && at_last;
            if (pop) begin
                if (col == CLW'(OUT_W - 1)) begin
                    col <= '0;
                    row <= (row == RW'(OUT_H - 1)) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CLW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_stream_tx.sv
// Bench for pool_stream_tx: queue-based reference of the pooled pixel stream,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_pool_stream_tx;

  localparam int CH    = 32;
  localparam int DW    = 32;
  localparam int OUT_H = 17;
  localparam int OUT_W = 13;
  localparam int DEPTH = 16;
  localparam int W     = CH * DW;
  localparam int FRAME = OUT_H * OUT_W;

  logic          clk;
  logic          rst;
  logic          valid_in;
  logic          ready_out;
  logic [DW-1:0] win [0:CH-1][0:1][0:1];
  logic [DW-1:0] data_out [0:CH-1];
  logic          valid_out;
  logic          ready_in;
  logic          last_out;
  logic          frame_done;

  pool_stream_tx #(
    .CH(CH), .DW(DW), .OUT_H(OUT_H), .OUT_W(OUT_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid_in(valid_in),
    .ready_out(ready_out),
    .win_in(win),
    .data_out(data_out),
    .valid_out(valid_out),
    .ready_in(ready_in),
    .last_out(last_out),
    .frame_done(frame_done)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: every accepted window set becomes one pooled pixel
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  int           cyc      = 0;
  int           pix_idx  = 0;
  bit           fd_exp   = 0;
  bit           armed    = 0;
  bit           prev_stall = 0;
  logic [W-1:0] prev_data;

  int n_acc = 0;
  int n_pop = 0;
  int n_last = 0;
  int n_fd = 0;
  int pops_since_rst = 0;
  int last_at = 0;
  bit acc_flag = 0;

  function automatic logic [W-1:0] pool_ref();
    logic [W-1:0] r;
    int signed m;
    int signed v;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      m = win[c][0][0];
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 2; j++) begin
          v = win[c][i][j];
          if (v > m) m = v;
        end
      end
      r[c*DW +: DW] = m;
    end
    return r;
  endfunction

  // scoreboard / compare process
  always @(negedge clk) begin
    logic [W-1:0] dpk;
    bit e_valid;
    bit e_ready;
    bit e_last;
    int bad_ch;
    cyc++;
    for (int c = 0; c < CH; c++) dpk[c*DW +: DW] = data_out[c];
    e_valid = (exp_q.size() > 0) && (cyc - acc_q[0] >= 3);
    e_ready = exp_q.size() < DEPTH;
    e_last  = e_valid && (pix_idx == FRAME - 1);
    if (armed) begin
      chk("valid_out", {31'd0, valid_out}, {31'd0, e_valid});
      chk("ready_out", {31'd0, ready_out}, {31'd0, e_ready});
      chk("last_out", {31'd0, last_out}, {31'd0, e_last});
      chk("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
      if (e_valid) begin
        bad_ch = -1;
        for (int c = CH - 1; c >= 0; c--) begin
          if (dpk[c*DW +: DW] !== exp_q[0][c*DW +: DW]) bad_ch = c;
        end
        total++;
        if (bad_ch >= 0) begin
          bad++;
          $display("FAIL data_out pixel %0d ch %0d: got %08h expected %08h", pix_idx, bad_ch,
                   dpk[bad_ch*DW +: DW], exp_q[0][bad_ch*DW +: DW]);
        end
      end
      if (prev_stall && e_valid) begin
        total++;
        if (dpk !== prev_data) begin
          bad++;
          $display("FAIL stall_stable: data_out changed while stalled, ch0 %08h was %08h",
                   dpk[DW-1:0], prev_data[DW-1:0]);
        end
      end
    end
    prev_stall = e_valid && !ready_in && !rst;
    prev_data  = dpk;

    // monitor counters from the DUT pins
    acc_flag = valid_in && ready_out && !rst;
    if (!rst) begin
      if (acc_flag) n_acc++;
      if (valid_out && ready_in) begin
        n_pop++;
        pops_since_rst++;
        if (last_out) begin
          n_last++;
          last_at = pops_since_rst;
        end
      end
      if (frame_done) n_fd++;
    end else begin
      pops_since_rst = 0;
    end

    // advance the model across the coming edge
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      pix_idx = 0;
      fd_exp  = 0;
      armed   = 1;
    end else begin
      fd_exp = 0;
      if (e_valid && ready_in) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        fd_exp  = (pix_idx == FRAME - 1);
        pix_idx = fd_exp ? 0 : pix_idx + 1;
      end
      if (valid_in && e_ready) begin
        exp_q.push_back(pool_ref());
        acc_q.push_back(cyc);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_win();
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          win[c][i][j] = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_in = 1'b0;
    step();
    rst = 1'b0;
  endtask

  int base_acc;
  int base_pop;
  int base_last;
  int base_fd;

  initial begin
    rst = 1'b1;
    valid_in = 1'b1;
    ready_in = 1'b1;
    rand_win();

    // reset held 3 cycles with valid_in asserted
    repeat (3) step();
    chk("rst_ready", {31'd0, ready_out}, 32'd1);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    chk("rst_data0", data_out[0], 32'd0);
    rst = 1'b0;
    valid_in = 1'b0;
    step();

    // signed max and latency
    rand_win();
    win[0][0][0] = 32'd5;        win[0][0][1] = 32'hFFFF_FFFD;
    win[0][1][0] = 32'd7;        win[0][1][1] = 32'd2;
    win[1][0][0] = 32'hFFFF_FFF8; win[1][0][1] = 32'hFFFF_FFFE;
    win[1][1][0] = 32'hFFFF_FFFB; win[1][1][1] = 32'hFFFF_FFF7;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) win[2][i][j] = 32'h8000_0000;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
    chk("lat_not_yet", {31'd0, valid_out}, 32'd0);
    step();
    chk("lat_valid", {31'd0, valid_out}, 32'd1);
    chk("max_ch0", data_out[0], 32'd7);
    chk("max_ch1", data_out[1], 32'hFFFF_FFFE);
    chk("max_ch2", data_out[2], 32'h8000_0000);
    repeat (3) step();
    do_reset();

    // one full frame back to back
    ready_in = 1'b1;
    base_last = n_last;
    base_fd = n_fd;
    base_pop = n_pop;
    for (int i = 0; i < FRAME; i++) begin
      rand_win();
      valid_in = 1'b1;
      step();
    end
    valid_in = 1'b0;
    repeat (8) step();
    chk("frame_pops", n_pop - base_pop, FRAME);
    chk("frame_last", n_last - base_last, 32'd1);
    chk("frame_fd", n_fd - base_fd, 32'd1);

    // backpressure: stalled sink, constant upstream
    ready_in = 1'b0;
    base_acc = n_acc;
    rand_win();
    valid_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (acc_flag) rand_win();
    end
    chk("bp_accepts", n_acc - base_acc, 32'd16);
    chk("bp_ready", {31'd0, ready_out}, 32'd0);
    chk("bp_valid", {31'd0, valid_out}, 32'd1);
    valid_in = 1'b0;
    ready_in = 1'b1;
    base_pop = n_pop;
    repeat (20) step();
    chk("bp_drain", n_pop - base_pop, 32'd16);
    chk("bp_empty", {31'd0, valid_out}, 32'd0);

    // random traffic for three frames
    do_reset();
    base_acc = n_acc;
    base_pop = n_pop;
    base_last = n_last;
    base_fd = n_fd;
    for (int k = 0; k < 20000 && (n_acc - base_acc) < 3 * FRAME; k++) begin
      if (!(valid_in && !acc_flag)) begin
        valid_in = ($urandom_range(0, 9) < 7);
        if (valid_in) rand_win();
      end
      ready_in = $urandom_range(0, 1);
      step();
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    repeat (30) step();
    chk("rand_accepts", n_acc - base_acc, 3 * FRAME);
    chk("rand_pops", n_pop - base_pop, 3 * FRAME);
    chk("rand_last", n_last - base_last, 32'd3);
    chk("rand_fd", n_fd - base_fd, 32'd3);

    // reset in the middle of a frame with pixels queued
    do_reset();
    ready_in = 1'b1;
    base_pop = n_pop;
    for (int k = 0; k < 1000 && (n_pop - base_pop) < 100; k++) begin
      rand_win();
      valid_in = 1'b1;
      step();
    end
    chk("mid_pops", n_pop - base_pop, 32'd100);
    ready_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rand_win();
      step();
    end
    valid_in = 1'b0;
    repeat (3) step();
    chk("mid_queued", {31'd0, valid_out}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_flush", {31'd0, valid_out}, 32'd0);
    chk("mid_ready", {31'd0, ready_out}, 32'd1);
    ready_in = 1'b1;
    base_last = n_last;
    for (int i = 0; i < FRAME; i++) begin
      rand_win();
      valid_in = 1'b1;
      step();
    end
    valid_in = 1'b0;
    repeat (8) step();
    chk("mid_last_cnt", n_last - base_last, 32'd1);
    chk("mid_last_at", last_at, FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
